// File: rtl/matrix_uart_tx.sv
// ---------------------------------------------------------------------------
// matrix_uart_tx
//   Prints an m x n matrix of unsigned bytes through a byte-wide UART
//   transmitter as decimal ASCII text. Elements in a row are separated by a
//   space and each row ends with CR LF. Leading zeros are suppressed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        print request, sampled only while idle
//   matrix_flat  row-major elements, element (i,j) at [(i*n+j)*8 +: 8]
//   m, n         row / column count (1..MAX_DIM legal)
//   tx_busy      transmitter busy flag
//   tx_data      byte to transmit (valid with tx_start, then held)
//   tx_start     one-cycle load strobe for the transmitter
//   busy         high whenever a job is in progress
//   done         one-cycle pulse after the last byte has left the transmitter
//   error        one-cycle pulse when the requested dimensions are illegal
//   dbg_state    current FSM state, for checkers and waveforms
//
// Transmitter handshake: a byte is handed over in a cycle where tx_start=1,
// which is only ever driven while tx_busy=0. The block then waits for the
// transmitter to raise tx_busy (accepted) and to drop it again (finished)
// before offering the next byte.
// ---------------------------------------------------------------------------
module matrix_uart_tx #(
  parameter int MAX_DIM = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [MAX_DIM*MAX_DIM*8-1:0]   matrix_flat,
  input  logic [2:0]                     m,
  input  logic [2:0]                     n,
  input  logic                           tx_busy,
  output logic [7:0]                     tx_data,
  output logic                           tx_start,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [2:0]                     dbg_state
);

  localparam int NUM_EL = MAX_DIM * MAX_DIM;
  localparam int IW     = $clog2(NUM_EL);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_EL - 1);
  localparam logic [2:0]    MAX_DIM3  = 3'(MAX_DIM);

  // Which character of the current element is being offered next.
  localparam logic [2:0] P_HUND = 3'd0;
  localparam logic [2:0] P_TENS = 3'd1;
  localparam logic [2:0] P_ONES = 3'd2;
  localparam logic [2:0] P_SEP  = 3'd3;  // space, or CR at end of row
  localparam logic [2:0] P_LF   = 3'd4;  // LF at end of row

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    elem_q [NUM_EL];
  logic [2:0]    m_q, n_q;
  logic [2:0]    row_q, col_q;
  logic [IW-1:0] idx_q;
  logic [2:0]    part_q;
  logic          last_q;     // final LF has been handed over
  logic [7:0]    tx_data_q;  // last byte handed over

  logic [7:0]    cur_el, next_el, dig_h, dig_t, dig_o, rem_h, cur_char;
  logic [IW-1:0] next_idx;
  logic          dims_bad, col_last, row_last;

  // First character of an element: skip leading zero digits.
  function automatic logic [2:0] first_part(input logic [7:0] v);
    if (v >= 8'd100)     first_part = P_HUND;
    else if (v >= 8'd10) first_part = P_TENS;
    else                 first_part = P_ONES;
  endfunction

  // ---------------- character generation ----------------
  always_comb begin
    cur_el   = elem_q[idx_q];
    dig_h    = cur_el / 8'd100;
    rem_h    = cur_el - dig_h * 8'd100;
    dig_t    = rem_h / 8'd10;
    dig_o    = rem_h - dig_t * 8'd10;
    next_idx = idx_q + IW'(1);
    next_el  = (idx_q != LAST_IDX) ? elem_q[next_idx] : 8'd0;
    col_last = (col_q == n_q - 3'd1);
    row_last = (row_q == m_q - 3'd1);
    dims_bad = (m_q == 3'd0) || (m_q > MAX_DIM3) ||
               (n_q == 3'd0) || (n_q > MAX_DIM3);
    case (part_q)
      P_HUND:  cur_char = 8'h30 + dig_h;
      P_TENS:  cur_char = 8'h30 + dig_t;
      P_ONES:  cur_char = 8'h30 + dig_o;
      P_SEP:   cur_char = col_last ? 8'h0D : 8'h20;
      P_LF:    cur_char = 8'h0A;
      default: cur_char = 8'h00;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start)    state_nxt = S_LOAD;
      S_LOAD:      state_nxt = dims_bad ? S_ERR : S_SEND;
      S_SEND:      if (!tx_busy) state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!tx_busy) state_nxt = last_q ? S_DONE : S_SEND;
      S_DONE:      state_nxt = S_IDLE;
      S_ERR:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // tx_data shows the fresh character in the strobe cycle and the held copy
  // otherwise, so it never changes between two strobes.
  always_comb begin
    tx_start  = (state == S_SEND) && !tx_busy;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    error     = (state == S_ERR);
    tx_data   = tx_start ? cur_char : tx_data_q;
    dbg_state = state;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_EL; k++) elem_q[k] <= 8'd0;
      m_q       <= 3'd0;
      n_q       <= 3'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      idx_q     <= '0;
      part_q    <= P_HUND;
      last_q    <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      if (state == S_IDLE && start) begin
        for (int k = 0; k < NUM_EL; k++) elem_q[k] <= matrix_flat[k*8 +: 8];
        m_q <= m;
        n_q <= n;
      end
      if (state == S_LOAD) begin
        row_q  <= 3'd0;
        col_q  <= 3'd0;
        idx_q  <= '0;
        part_q <= first_part(elem_q[0]);
        last_q <= 1'b0;
      end
      if (tx_start) begin
        tx_data_q <= cur_char;
        case (part_q)
          P_HUND: part_q <= P_TENS;
          P_TENS: part_q <= P_ONES;
          P_ONES: part_q <= P_SEP;
          P_SEP: begin
            if (col_last) begin
              part_q <= P_LF;
            end else begin
              col_q  <= col_q + 3'd1;
              idx_q  <= next_idx;
              part_q <= first_part(next_el);
            end
          end
          P_LF: begin
            if (row_last) begin
              last_q <= 1'b1;
            end else begin
              row_q  <= row_q + 3'd1;
              col_q  <= 3'd0;
              idx_q  <= next_idx;
              part_q <= first_part(next_el);
            end
          end
          default: part_q <= P_ONES;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_matrix_uart_tx
//   Directed and randomised print jobs for matrix_uart_tx. Expected byte
//   streams are built from the matrix with $sformatf and queued at start;
//   observed bytes are recorded by a passive monitor and compared against
//   the queue when each job ends. A simple transmitter model drives tx_busy.
// ---------------------------------------------------------------------------
module tb_matrix_uart_tx;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [199:0] matrix_flat;
  logic [2:0]   m, n;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_start, busy, done, error;
  logic [2:0]   dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matrix_uart_tx #(.MAX_DIM(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_flat (matrix_flat),
    .m           (m),
    .n           (n),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_mem [512];

  int tx_total   = 0;
  int done_total = 0;
  int err_total  = 0;
  int viol_total = 0;  // tx_start seen while tx_busy high
  int hold_viol  = 0;  // tx_data changed between strobes
  int first_cyc  = 0;
  int err_cyc    = 0;
  logic [7:0] last_tx = 8'd0;

  int job_base = 0;
  int exp_len  = 0;
  int s_cyc    = 0;
  int d0, e0, v0, h0;

  int   busy_len  = 10;
  logic hold_busy = 1'b0;
  logic busy_m    = 1'b0;
  int   served    = 0;
  int   bcnt      = 0;

  assign tx_busy = busy_m | hold_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor (sampled on falling edge) ----------------
  always @(negedge clk) begin
    if (!rst_n) last_tx = 8'd0;
    if (tx_start) begin
      obs_mem[tx_total % 512] = tx_data;
      if (tx_total == job_base) first_cyc = cyc;
      if (tx_busy) viol_total++;
      last_tx = tx_data;
      tx_total++;
    end else if (rst_n && tx_data !== last_tx) begin
      hold_viol++;
    end
    if (done) done_total++;
    if (error) begin
      err_total++;
      err_cyc = cyc;
    end
  end

  // ---------------- transmitter model ----------------
  always @(posedge clk) begin
    #1;
    if (tx_total != served) begin
      served = tx_total;
      bcnt   = busy_len;
    end else if (bcnt > 0) begin
      bcnt = bcnt - 1;
    end
    busy_m = (bcnt > 0);
  end

  // ---------------- global watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic build_exp(input int jm, input int jn, input logic [199:0] jf);
    string s;
    logic [7:0] v;
    for (int i = 0; i < jm; i++) begin
      for (int j = 0; j < jn; j++) begin
        v = jf[(i*jn+j)*8 +: 8];
        s = $sformatf("%0d", v);
        for (int c = 0; c < s.len(); c++) exp_q.push_back(s[c]);
        if (j < jn - 1) exp_q.push_back(8'h20);
        else begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end
      end
    end
  endtask

  task automatic start_job(input logic [2:0] jm, input logic [2:0] jn,
                           input logic [199:0] jf, input bit legal);
    exp_q.delete();
    if (legal) build_exp(int'(jm), int'(jn), jf);
    exp_len  = exp_q.size();
    job_base = tx_total;
    d0 = done_total; e0 = err_total; v0 = viol_total; h0 = hold_viol;
    @(negedge clk);
    m = jm; n = jn; matrix_flat = jf; start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    // scramble inputs: the job must run from the latched copy
    m = 3'($urandom_range(0, 7));
    n = 3'($urandom_range(0, 7));
    for (int k = 0; k < 25; k++) matrix_flat[k*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  task automatic finish_job(input string tag, input bit exp_err, input bit chk_lat);
    int got;
    int busy_low = 0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #2;
      if (done_total != d0 || err_total != e0) break;
      if (busy !== 1'b1) busy_low++;
    end
    check({tag, "_done_cnt"}, done_total - d0, exp_err ? 0 : 1);
    check({tag, "_err_cnt"},  err_total - e0,  exp_err ? 1 : 0);
    check({tag, "_busy_held"}, busy_low, 0);
    if (exp_err) check({tag, "_err_lat"}, err_cyc - s_cyc, 2);
    else if (chk_lat) check({tag, "_first_lat"}, first_cyc - s_cyc, 2);
    got = tx_total - job_base;
    check({tag, "_byte_cnt"}, got, exp_len);
    for (int k = 0; k < got && k < 200; k++) begin
      if (exp_q.size() > 0)
        check($sformatf("%s_byte%0d", tag, k), obs_mem[(job_base + k) % 512], exp_q.pop_front());
    end
    check({tag, "_tx_while_busy"}, viol_total - v0, 0);
    check({tag, "_data_hold"}, hold_viol - h0, 0);
    got = tx_total;
    repeat (5) @(posedge clk);
    #2;
    check({tag, "_idle_after"}, {29'd0, busy, tx_start, dbg_state == 3'd0}, 32'd1);
    check({tag, "_quiet_after"}, tx_total - got, 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [199:0] f;
  int           base5;

  initial begin
    rst_n = 1'b0; start = 1'b0; m = 3'd0; n = 3'd0; matrix_flat = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {19'd0, tx_data, tx_start, busy, done, error}, 32'd0);
    check("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {19'd0, tx_data, tx_start, busy, done, error}, 32'd0);

    // 2x3, elements 1..6, 10-cycle transmitter
    busy_len = 10;
    f = '0;
    for (int k = 0; k < 6; k++) f[k*8 +: 8] = 8'(k + 1);
    start_job(3'd2, 3'd3, f, 1'b1);
    finish_job("m2x3", 1'b0, 1'b1);

    // 1x1 zero
    f = '0;
    start_job(3'd1, 3'd1, f, 1'b1);
    finish_job("m1x1", 1'b0, 1'b1);

    // 1x2: 255, 10
    f = '0; f[7:0] = 8'd255; f[15:8] = 8'd10;
    start_job(3'd1, 3'd2, f, 1'b1);
    finish_job("m1x2", 1'b0, 1'b1);

    // illegal dimensions
    start_job(3'd0, 3'd3, f, 1'b0);
    finish_job("bad_m0", 1'b1, 1'b0);
    start_job(3'd6, 3'd1, f, 1'b0);
    finish_job("bad_m6", 1'b1, 1'b0);
    start_job(3'd2, 3'd7, f, 1'b0);
    finish_job("bad_n7", 1'b1, 1'b0);

    // busy transmitter: held high at start, 20 cycles per byte, start mid-job
    busy_len = 20; hold_busy = 1'b1;
    f = '0;
    for (int k = 0; k < 6; k++) f[k*8 +: 8] = 8'(k + 1);
    start_job(3'd2, 3'd3, f, 1'b1);
    repeat (15) @(posedge clk);
    #2;
    check("busyhold_no_tx", tx_total - job_base, 0);
    check("busyhold_state", dbg_state, 3'd2);
    hold_busy = 1'b0;
    for (int c = 0; c < 2000 && tx_total - job_base < 3; c++) @(posedge clk);
    @(negedge clk);
    m = 3'd1; n = 3'd1; matrix_flat = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_job("busytx", 1'b0, 1'b0);

    // random legal job
    busy_len = int'($urandom_range(2, 6));
    for (int k = 0; k < 25; k++) f[k*8 +: 8] = 8'($urandom_range(0, 255));
    start_job(3'($urandom_range(1, 5)), 3'($urandom_range(1, 5)), f, 1'b1);
    finish_job("rand", 1'b0, 1'b1);

    // reset in the middle of a 5x5 job
    busy_len = 4;
    for (int k = 0; k < 25; k++) f[k*8 +: 8] = 8'($urandom_range(100, 255));
    start_job(3'd5, 3'd5, f, 1'b1);
    for (int c = 0; c < 2000 && tx_total - job_base < 5; c++) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {19'd0, tx_data, tx_start, busy, done, error}, 32'd0);
    check("midrst_state", dbg_state, 3'd0);
    check("midrst_prefix_cnt", tx_total - job_base, 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("midrst_byte%0d", k), obs_mem[(job_base + k) % 512], exp_q.pop_front());
    exp_q.delete();
    base5 = tx_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_resume", tx_total - base5, 0);

    f = '0;
    for (int k = 0; k < 4; k++) f[k*8 +: 8] = 8'd9;
    start_job(3'd2, 3'd2, f, 1'b1);
    finish_job("after_rst", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_uart_tx.md
MATRIX_UART_TX -- requirements
Module: matrix_uart_tx

Interface
REQ-001 Parameter: MAX_DIM, default 5, largest legal row or column count.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  print request; sampled only in IDLE.
REQ-005 matrix_flat  input  200  row-major elements; element (i,j) at bits [(i*n+j)*8 +: 8], unsigned 0..255.
REQ-006 m  input  3  row count.
REQ-007 n  input  3  column count.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_data  output  8  ASCII byte to transmit.
REQ-010 tx_start  output  1  one-cycle pulse: transmitter loads tx_data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the whole matrix has been sent.
REQ-013 error  output  1  one-cycle pulse when dimensions are illegal.

Function
REQ-014 The block SHALL latch matrix_flat, m and n on the cycle that start=1 is sampled in IDLE; later input changes SHALL have no effect on that print job.
REQ-015 States SHALL be IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE, DONE and ERR.
REQ-016 Transitions:
- IDLE -> LOAD on start.
- LOAD -> ERR if m or n is 0 or greater than MAX_DIM; otherwise LOAD -> SEND.
- SEND -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_IDLE when tx_busy=1.
- WAIT_IDLE, when tx_busy=0: -> SEND if characters remain, otherwise -> DONE.
- DONE -> IDLE.
- ERR -> IDLE.
REQ-017 SEND SHALL be entered only when tx_busy=0. If tx_busy=1 on entry, the block SHALL hold in SEND without pulsing tx_start until tx_busy=0.
REQ-018 tx_start SHALL be high for exactly one cycle per character. tx_data SHALL be valid on that cycle and SHALL hold until the next tx_start.
REQ-019 With tx_busy=0, the first tx_start SHALL assert exactly 2 cycles after the start-sampling cycle.
REQ-020 Each element SHALL be printed in decimal ASCII (0x30+digit), most-significant digit first, with leading zeros suppressed: 0 -> "0", 42 -> "42", 255 -> "255".
REQ-021 Separators:
- After element (i,j) with j<n-1: 0x20 (space).
- After element (i,n-1): 0x0D then 0x0A.
REQ-022 Elements SHALL be sent in row-major order, i=0..m-1 and j=0..n-1. The character count SHALL be the sum of the digit counts plus m*(n-1) spaces plus 2*m line-end bytes; the maximum is 105 for a 5x5 matrix of 3-digit values.
REQ-023 Digit extraction SHALL use 8-bit hundreds/tens/ones arithmetic with no truncation across 0..255.
REQ-024 done SHALL pulse in the DONE cycle, which is the cycle after tx_busy falls following the final 0x0A.
REQ-025 error SHALL pulse in the ERR cycle, which is the cycle after LOAD, with no tx_start in that job.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 A 1x1 matrix SHALL send its digits then 0x0D 0x0A exactly once, with no repeated element or line end.

Reset
REQ-028 On rst_n=0 the block SHALL immediately, without waiting for a clock edge:
- set state to IDLE;
- clear tx_data, tx_start, busy, done, error, all counters and latched data to 0.
REQ-029 Reset mid-transmission SHALL abandon the job with no further tx_start. The next start after reset release SHALL send the new matrix from element (0,0).

Verification
REQ-030 Scenario 2x3 matrix: m=2, n=3, elements 1..6, tx_busy model 10 cycles per byte -> byte stream "1 2 3\r\n4 5 6\r\n", i.e. 14 tx_start pulses, then one done pulse; busy high throughout.
REQ-031 Scenario 1x1 zero: m=1, n=1, element 0 -> 0x30 0x0D 0x0A, then done; nothing further.
REQ-032 Scenario 1x2 multi-digit: m=1, n=2, elements 255 and 10 -> "255 10\r\n", 8 bytes.
REQ-033 Scenario illegal dimensions, each case separately:
- m=0, n=3;
- m=6, n=1.
Each SHALL give one error pulse exactly 2 cycles after start, zero tx_start, and a return to IDLE.
REQ-034 Scenario busy transmitter:
- tx_busy held high 20 cycles after each tx_start, and held high at the time of start -> no tx_start while tx_busy=1; all 14 bytes of REQ-030 still correct.
- start pulsed mid-job -> ignored.
REQ-035 Scenario reset mid-job: rst_n low after the 5th byte of a 5x5 job -> all outputs 0 at once. After release, a 2x2 job of elements 9 -> "9 9\r\n9 9\r\n".
